// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: MIPS opcodes, request
// kind codes and the load-session FSM state type.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_BEQ = 3'd1;
  localparam logic [2:0] KIND_LW  = 3'd2;
  localparam logic [2:0] KIND_SW  = 3'd3;
  localparam logic [2:0] KIND_J   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: request kind plus instruction fields -> 32-bit MIPS
// word, with a legal flag that is low for kind codes 5..7.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // NOTE: every output of an always_comb gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      KIND_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      KIND_LW:  word = {OP_LW, rs, rt, imm};
      KIND_SW:  word = {OP_SW, rs, rt, imm};
      KIND_J:   word = {OP_J, target};
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded MIPS instructions into instruction memory, one word per
// accepted request, stopping on the last request, an illegal kind or a full memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic              last_q;
  logic [31:0]       word;
  logic              legal;
  logic              fire;
  logic              start_ok;
  logic              overflow;

  instr_field_packer u_packer (
    .kind   (req_kind),
    .rs     (req_rs),
    .rt     (req_rt),
    .rd     (req_rd),
    .shamt  (req_shamt),
    .funct  (req_funct),
    .imm    (req_imm),
    .target (req_target),
    .word   (word),
    .legal  (legal)
  );

  // req_ready is registered and high exactly while in ACCEPT.
  assign fire     = (state == S_ACCEPT) && req_valid && req_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  // imem_addr holds the address being written during WRITE.
  assign overflow = (state == S_WRITE) && !last_q && (imem_addr == LAST_ADDR);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_ACCEPT;
      S_ACCEPT: if (fire) state_n = legal ? S_WRITE : S_DONE;
      S_WRITE:  state_n = (last_q || imem_addr == LAST_ADDR) ? S_DONE : S_ACCEPT;
      S_DONE:   if (start) state_n = S_ACCEPT;
      default:  state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      imem_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      ptr        <= '0;
      last_q     <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == S_ACCEPT);
      imem_we   <= (state_n == S_WRITE);
      busy      <= (state_n == S_ACCEPT) || (state_n == S_WRITE);
      done      <= (state_n == S_DONE);

      if (start_ok) begin
        ptr        <= '0;
        word_count <= '0;
        err        <= 1'b0;
      end

      if (fire) begin
        if (legal) begin
          imem_addr  <= ptr;
          imem_wdata <= word;
          last_q     <= req_last;
          ptr        <= ptr + 1'b1;
          word_count <= word_count + 1'b1;
        end else begin
          err <= 1'b1;
        end
      end

      if (overflow) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-size instance plus an
// ADDR_W=2 instance for the memory-full case.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_kind = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [5:0]  req_funct = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        req_last = 1'b0;

  logic        req_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        req_ready2, imem_we2, busy2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid),
    .req_ready(req_ready), .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_shamt(req_shamt), .req_funct(req_funct),
    .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .req_valid(req_valid),
    .req_ready(req_ready2), .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_shamt(req_shamt), .req_funct(req_funct),
    .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .busy(busy2), .done(done2), .err(err2), .word_count(word_count2)
  );

  logic        sel_small = 1'b0;
  logic        cur_ready, cur_we, cur_busy, cur_done, cur_err;
  logic [31:0] cur_addr, cur_wdata, cur_wc;

  assign cur_ready = sel_small ? req_ready2 : req_ready;
  assign cur_we    = sel_small ? imem_we2   : imem_we;
  assign cur_busy  = sel_small ? busy2      : busy;
  assign cur_done  = sel_small ? done2      : done;
  assign cur_err   = sel_small ? err2       : err;
  assign cur_addr  = sel_small ? {30'd0, imem_addr2}  : {24'd0, imem_addr};
  assign cur_wdata = sel_small ? imem_wdata2 : imem_wdata;
  assign cur_wc    = sel_small ? {29'd0, word_count2} : {23'd0, word_count};

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    if (sel_small) start2 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                         input logic [25:0] target, input logic last);
    req_kind   = kind;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_shamt  = '0;
    req_funct  = funct;
    req_imm    = imm;
    req_target = target;
    req_last   = last;
    req_valid  = 1'b1;
  endtask

  // Holds req_valid until the handshake edge (bounded), then drops it.
  task automatic handshake(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cur_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    check({tag, " accepted"}, {31'd0, ok}, 32'd1);
  endtask

  // Called in the cycle after the handshake: the WRITE cycle.
  task automatic expect_write(input string tag, input logic [31:0] addr,
                              input logic [31:0] word, input logic ready_after);
    check({tag, " we"}, {31'd0, cur_we}, 32'd1);
    check({tag, " addr"}, cur_addr, addr);
    check({tag, " wdata"}, cur_wdata, word);
    check({tag, " ready_in_write"}, {31'd0, cur_ready}, 32'd0);
    tick();
    check({tag, " we_one_cycle"}, {31'd0, cur_we}, 32'd0);
    check({tag, " ready_after"}, {31'd0, cur_ready}, {31'd0, ready_after});
  endtask

  task automatic expect_status(input string tag, input logic d, input logic e, input logic [31:0] wc);
    check({tag, " done"}, {31'd0, cur_done}, {31'd0, d});
    check({tag, " err"}, {31'd0, cur_err}, {31'd0, e});
    check({tag, " word_count"}, cur_wc, wc);
    check({tag, " busy"}, {31'd0, cur_busy}, {31'd0, !d});
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, " ready"}, {31'd0, cur_ready}, 32'd0);
    check({tag, " we"}, {31'd0, cur_we}, 32'd0);
    check({tag, " busy"}, {31'd0, cur_busy}, 32'd0);
    check({tag, " done"}, {31'd0, cur_done}, 32'd0);
    check({tag, " err"}, {31'd0, cur_err}, 32'd0);
    check({tag, " addr"}, cur_addr, 32'd0);
    check({tag, " wdata"}, cur_wdata, 32'd0);
    check({tag, " word_count"}, cur_wc, 32'd0);
  endtask

  initial begin
    logic saw_we;

    tick();
    tick();
    reset = 1'b0;
    expect_reset_outputs("reset");
    sel_small = 1'b1;
    expect_reset_outputs("reset_small");
    sel_small = 1'b0;

    // req_valid held while IDLE: nothing is accepted or written.
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    saw_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_we |= cur_we;
      check("idle_ready", {31'd0, cur_ready}, 32'd0);
    end
    check("idle_no_write", {31'd0, saw_we}, 32'd0);
    req_valid = 1'b0;

    // Single R-type, last.
    pulse_start();
    check("start_ready", {31'd0, cur_ready}, 32'd1);
    check("start_busy", {31'd0, cur_busy}, 32'd1);
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    handshake("r1");
    expect_write("r1", 32'd0, 32'h0022_1820, 1'b0);
    expect_status("r1_end", 1'b1, 1'b0, 32'd1);

    // Back-to-back lw, sw, beq, j.
    pulse_start();
    check("restart_done_cleared", {31'd0, cur_done}, 32'd0);
    check("restart_wc_cleared", cur_wc, 32'd0);
    set_req(KIND_LW, 5'd9, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0);
    handshake("lw");
    expect_write("lw", 32'd0, 32'h8D28_0004, 1'b1);
    set_req(KIND_SW, 5'd29, 5'd31, 5'd0, 6'h0, 16'h0000, 26'h0, 1'b0);
    handshake("sw");
    expect_write("sw", 32'd1, 32'hAFBF_0000, 1'b1);
    set_req(KIND_BEQ, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
    handshake("beq");
    expect_write("beq", 32'd2, 32'h1022_FFFF, 1'b1);
    set_req(KIND_J, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1);
    handshake("j");
    expect_write("j", 32'd3, 32'h0800_0010, 1'b0);
    expect_status("seq_end", 1'b1, 1'b0, 32'd4);

    // Illegal kind after one legal word.
    pulse_start();
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    handshake("pre_illegal");
    expect_write("pre_illegal", 32'd0, 32'h0022_1820, 1'b1);
    set_req(3'd6, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    handshake("illegal");
    check("illegal_no_write", {31'd0, cur_we}, 32'd0);
    expect_status("illegal_end", 1'b1, 1'b1, 32'd1);
    pulse_start();
    check("illegal_err_cleared", {31'd0, cur_err}, 32'd0);
    set_req(KIND_LW, 5'd9, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
    handshake("after_illegal");
    expect_write("after_illegal", 32'd0, 32'h8D28_0004, 1'b0);
    expect_status("after_illegal_end", 1'b1, 1'b0, 32'd1);

    // Overflow on the ADDR_W=2 instance.
    sel_small = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
      handshake("ovf");
      expect_write("ovf", i, 32'h0022_1820, (i < 3) ? 1'b1 : 1'b0);
    end
    expect_status("ovf_end", 1'b1, 1'b1, 32'd4);
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    saw_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_we |= cur_ready | cur_we;
      tick();
    end
    req_valid = 1'b0;
    check("ovf_fifth_rejected", {31'd0, saw_we}, 32'd0);
    check("ovf_wc_held", cur_wc, 32'd4);
    sel_small = 1'b0;

    // Reset during WRITE drops the write.
    pulse_start();
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    handshake("pre_reset");
    check("pre_reset we", {31'd0, cur_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_reset_outputs("reset_in_write");
    pulse_start();
    set_req(KIND_SW, 5'd29, 5'd31, 5'd0, 6'h0, 16'h0000, 26'h0, 1'b0);
    handshake("post_reset");
    expect_write("post_reset", 32'd0, 32'hAFBF_0000, 1'b1);

    // start pulsed during ACCEPT is ignored: pointer keeps advancing.
    pulse_start();
    check("start_in_accept_ready", {31'd0, cur_ready}, 32'd1);
    set_req(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    handshake("ignored_start");
    expect_write("ignored_start", 32'd1, 32'h0022_1820, 1'b0);
    expect_status("ignored_start_end", 1'b1, 1'b0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder/writer counterpart of the main control decoder. It accepts field-level instruction requests over a valid/ready handshake, packs each into a 32-bit MIPS word (R-type, beq, lw, sw, j), and writes the words sequentially into instruction memory. It sits between a test or boot host and the instruction memory. It is used to load programs before the single-cycle core is released from reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a load session; accepted only in IDLE or DONE
req_valid  in  1  host request valid
req_ready  out  1  encoder ready to accept a request
req_kind  in  3  0=R-type, 1=beq, 2=lw, 3=sw, 4=j, 5..7=illegal
req_rs  in  5  rs field
req_rt  in  5  rt field
req_rd  in  5  rd field (R-type only)
req_shamt  in  5  shamt field (R-type only)
req_funct  in  6  funct field (R-type only)
req_imm  in  16  immediate/offset (beq, lw, sw)
req_target  in  26  jump target (j)
req_last  in  1  marks the final request of the session
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  encoded instruction
busy  out  1  session in progress (ACCEPT or WRITE)
done  out  1  session finished; held until next start or reset
err  out  1  sticky error: illegal kind or overflow
word_count  out  ADDR_W+1  number of words written this session

Behaviour:
- All outputs are registered. Reset: state=IDLE; req_ready, imem_we, busy, done, err = 0; imem_addr, imem_wdata, word_count = 0.
- Encoding:
  - R = {000000, rs, rt, rd, shamt, funct}
  - beq = {000100, rs, rt, imm}
  - lw = {100011, rs, rt, imm}
  - sw = {101011, rs, rt, imm}
  - j = {000010, target}
  - Fields unused by a kind are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: req_ready=0. start -> ACCEPT; clears ptr, word_count, err, done.
  - ACCEPT: req_ready=1, busy=1. On req_valid & req_ready:
    - Legal kind: latch the encoded word, ptr, and last flag; go to WRITE.
    - Illegal kind: no write; err=1; go to DONE.
  - WRITE: req_ready=0, imem_we=1 for exactly one cycle with imem_addr=ptr; word_count+1; ptr+1.
    - Latched last -> DONE.
    - Else ptr was DEPTH-1 (memory full) -> err=1, DONE (overflow; no wrap-around).
    - Else -> ACCEPT.
  - DONE: done=1, busy=0, req_ready=0. start -> ACCEPT with a fresh session (ptr=0; err, done, word_count cleared).
- Latency:
  - Handshake at cycle N -> imem_we at N+1 -> req_ready high again at N+2.
  - Maximum throughput is one word per 2 cycles.
- start is ignored in ACCEPT and WRITE. req_valid is ignored whenever req_ready=0.
- If a write to address DEPTH-1 carries req_last=1, the session ends in DONE with err=0.
- word_count saturates naturally at DEPTH, so its width is ADDR_W+1.
- Reset asserted in any state forces IDLE on the next edge. A pending write is dropped, and imem_we is low in the cycle after reset.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_LW=6'b100011, OP_SW=6'b101011, OP_J=6'b000010
  - req_kind encodings KIND_R..KIND_J
  - FSM state typedef
- One combinational sub-module, instr_field_packer, maps kind plus fields to {word, legal}. The FSM, pointer, and handshake logic stay in the top module.

Test Plan:
- start; R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, last=1 -> imem_we one cycle, addr 0, wdata 0x00221820; done=1, err=0, word_count=1.
- Back-to-back lw rs=9 rt=8 imm=4; sw rs=29 rt=31 imm=0; beq rs=1 rt=2 imm=0xFFFF; j target=0x10 (last) -> writes 0x8D280004@0, 0xAFBF0000@1, 0x1022FFFF@2, 0x08000010@3; req_ready low in every WRITE cycle; word_count=4.
- Request with kind=6 after one legal word -> no write for the illegal request; err=1, done=1, word_count=1; next start clears err and writes at addr 0.
- ADDR_W=2; 5 requests, none marked last -> words at 0..3; then err=1, done=1, word_count=4; 5th request never accepted.
- reset asserted in the WRITE cycle -> imem_we=0 next cycle; all outputs at reset values; start then writes at addr 0.
- start pulsed during ACCEPT and req_valid held while in IDLE -> start ignored (ptr unchanged); no write occurs while in IDLE.
